// File: rtl/qdr_tester_pkg.sv
// Shared types for the QDR user-port tester: FSM states, counter widths and the address-derived test pattern.
// Pure declarations; no timing or flow control of its own.
package qdr_tester_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int PAT_MAX_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Word for address a: lo = a (optionally inverted), hi = ~lo. Caller truncates to 2*dw bits.
  function automatic logic [2*PAT_MAX_W-1:0] pattern(input logic [PAT_MAX_W-1:0] addr,
                                                      input logic                 inv,
                                                      input int                   dw);
    logic [2*PAT_MAX_W-1:0] w;
    w = '0;
    for (int i = 0; i < PAT_MAX_W; i++) begin
      if (i < dw) begin
        w[i]      = addr[i] ^ inv;
        w[i + dw] = ~(addr[i] ^ inv);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/qdr_tester_fifo.sv
// Synchronous FIFO tracking read addresses in flight; head visible combinationally, push/pop same cycle allowed.
// Push while full is dropped unless a pop happens in the same cycle; flush empties it in one cycle.
module qdr_tester_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 16
) (
  input  logic                   clk0,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk0) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk0) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/qdr_usr_tester.sv
// Write/readback memory tester on the QDR controller user port; first write strobe the cycle after start is accepted.
// Read issue stalls while MAX_OUTSTANDING reads are unanswered; returns are accepted every cycle with no backpressure.
module qdr_usr_tester
  import qdr_tester_pkg::*;
#(
  parameter int DATA_WIDTH      = 18,
  parameter int BW_WIDTH        = 2,
  parameter int ADDR_WIDTH      = 22,
  parameter int TEST_ADDR_BITS  = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int RD_TIMEOUT      = 64,
  parameter int WR_RD_GAP       = 16
) (
  input  logic                      clk0,
  input  logic                      reset_n,
  input  logic                      phy_rdy,
  input  logic                      start,
  input  logic                      invert,
  output logic                      usr_rd_strb,
  output logic                      usr_wr_strb,
  output logic [ADDR_WIDTH-1:0]     usr_addr,
  output logic [2*DATA_WIDTH-1:0]   usr_wr_data,
  output logic [2*BW_WIDTH-1:0]     usr_wr_be,
  input  logic [2*DATA_WIDTH-1:0]   usr_rd_data,
  input  logic                      usr_rd_dvld,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [ERR_CNT_W-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TMR_W = 16;
  localparam logic [TEST_ADDR_BITS-1:0] LAST_IDX = '1;
  localparam logic [TMR_W-1:0]          GAP_LAST = TMR_W'(WR_RD_GAP - 1);
  localparam logic [TMR_W-1:0]          TO_LAST  = TMR_W'(RD_TIMEOUT - 1);

  typedef logic [2*DATA_WIDTH-1:0] word_t;

  state_t                    state;
  logic [TEST_ADDR_BITS-1:0] idx;
  logic [TEST_ADDR_BITS-1:0] pat_idx;
  logic                      pat_inv;
  logic                      inv_q;
  logic                      first_seen;
  logic [TMR_W-1:0]          gap_cnt;
  logic [TMR_W-1:0]          to_cnt;
  word_t                     wr_word;
  word_t                     exp_word;
  logic [ERR_CNT_W-1:0]      err_nxt;

  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_flush;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [ADDR_WIDTH-1:0]     fifo_head;
  logic [CNT_W-1:0]          fifo_count;

  logic rx_act, mismatch, spurious, gap_done, can_push, issue;
  logic abort, to_hit, wait_done, finish;

  assign usr_wr_be = '1;

  // Next write word: address 0 with the live invert input at start, else the following address.
  always_comb begin
    pat_idx = (state == ST_IDLE) ? '0 : idx + 1'b1;
    pat_inv = (state == ST_IDLE) ? invert : inv_q;
  end

  assign wr_word  = word_t'(pattern(PAT_MAX_W'(pat_idx), pat_inv, DATA_WIDTH));
  assign exp_word = word_t'(pattern(PAT_MAX_W'(fifo_head), inv_q, DATA_WIDTH));

  assign rx_act   = (state == ST_READ) || (state == ST_WAIT);
  assign fifo_pop = rx_act && usr_rd_dvld && !fifo_empty;
  assign mismatch = fifo_pop && (usr_rd_data != exp_word);
  assign spurious = rx_act && usr_rd_dvld && fifo_empty;

  always_comb begin
    err_nxt = err_count;
    if ((mismatch || spurious) && (err_count != '1)) err_nxt = err_count + 1'b1;
  end

  // A slot freed by this cycle's return may be reused by this cycle's issue.
  assign gap_done  = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign can_push  = !fifo_full || fifo_pop;
  assign issue     = ((state == ST_READ) || gap_done) && can_push && phy_rdy;
  assign fifo_push = issue;

  assign abort     = (state inside {ST_WRITE, ST_GAP, ST_READ, ST_WAIT}) && !phy_rdy;
  assign to_hit    = rx_act && !fifo_empty && !usr_rd_dvld && (to_cnt == TO_LAST);
  assign wait_done = (state == ST_WAIT) && (fifo_count == '0);
  assign finish    = abort || to_hit || wait_done;
  assign fifo_flush = finish;

  qdr_tester_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_exp_fifo (
    .clk0    (clk0),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .din     (ADDR_WIDTH'(idx)),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk0) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      inv_q          <= 1'b0;
      first_seen     <= 1'b0;
      gap_cnt        <= '0;
      to_cnt         <= '0;
      usr_rd_strb    <= 1'b0;
      usr_wr_strb    <= 1'b0;
      usr_addr       <= '0;
      usr_wr_data    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      err_count <= err_nxt;
      to_cnt    <= (rx_act && !fifo_empty && !usr_rd_dvld) ? to_cnt + 1'b1 : '0;

      if (mismatch && !first_seen) begin
        first_seen     <= 1'b1;
        first_err_addr <= fifo_head;
      end

      case (state)
        ST_IDLE: begin
          if (start && phy_rdy) begin
            state          <= ST_WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
            inv_q          <= invert;
            idx            <= '0;
            usr_wr_strb    <= 1'b1;
            usr_addr       <= '0;
            usr_wr_data    <= wr_word;
          end
        end
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            usr_wr_strb <= 1'b0;
            idx         <= '0;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end else begin
            idx         <= pat_idx;
            usr_addr    <= ADDR_WIDTH'(pat_idx);
            usr_wr_data <= wr_word;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_done) state <= ST_READ;
        end
        ST_READ: begin
          if (!issue) usr_rd_strb <= 1'b0;
        end
        ST_WAIT: usr_rd_strb <= 1'b0;
        default: state <= ST_IDLE;
      endcase

      if (issue) begin
        usr_rd_strb <= 1'b1;
        usr_addr    <= ADDR_WIDTH'(idx);
        if (idx == LAST_IDX) state <= ST_WAIT;
        else                 idx   <= idx + 1'b1;
      end

      // Completion, timeout and abort all retire through here; the FIFO is flushed alongside.
      if (finish) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        done        <= 1'b1;
        usr_rd_strb <= 1'b0;
        usr_wr_strb <= 1'b0;
        usr_addr    <= '0;
        usr_wr_data <= '0;
        to_cnt      <= '0;
        timeout     <= to_hit && !abort;
        pass        <= !abort && !to_hit && (err_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_qdr_usr_tester.sv
// Bench for qdr_usr_tester: behavioural QDR controller model plus scoreboard of expected writes, reads and run results.
module tb_qdr_usr_tester;

  localparam int DW  = 18;
  localparam int BW  = 2;
  localparam int AW  = 22;
  localparam int TAB = 4;
  localparam int MO  = 16;
  localparam int RTO = 64;
  localparam int GAP = 16;
  localparam int NW  = 1 << TAB;

  typedef logic [2*DW-1:0] word_t;
  typedef struct { logic [AW-1:0] addr; word_t data; } wr_t;
  typedef struct { logic pass; logic tmo; logic [15:0] errs; logic [AW-1:0] first; } res_t;

  logic            clk0 = 1'b0;
  logic            reset_n, phy_rdy, start, invert;
  logic            usr_rd_strb, usr_wr_strb;
  logic [AW-1:0]   usr_addr;
  word_t           usr_wr_data;
  logic [2*BW-1:0] usr_wr_be;
  word_t           usr_rd_data;
  logic            usr_rd_dvld;
  logic            busy, done, pass, timeout;
  logic [15:0]     err_count;
  logic [AW-1:0]   first_err_addr;

  always #5 clk0 = ~clk0;

  qdr_usr_tester #(
    .DATA_WIDTH(DW), .BW_WIDTH(BW), .ADDR_WIDTH(AW), .TEST_ADDR_BITS(TAB),
    .MAX_OUTSTANDING(MO), .RD_TIMEOUT(RTO), .WR_RD_GAP(GAP)
  ) dut (
    .clk0(clk0), .reset_n(reset_n), .phy_rdy(phy_rdy), .start(start), .invert(invert),
    .usr_rd_strb(usr_rd_strb), .usr_wr_strb(usr_wr_strb), .usr_addr(usr_addr),
    .usr_wr_data(usr_wr_data), .usr_wr_be(usr_wr_be), .usr_rd_data(usr_rd_data),
    .usr_rd_dvld(usr_rd_dvld), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd[$];
  res_t          exp_res[$];

  word_t         mem[NW];
  word_t         flip[NW];
  int            lat = 10;
  bit            no_ret = 0;
  logic [AW-1:0] mdl_q[$];
  int            mdl_due[$];
  int            outst = 0, max_outst = 0, strobe_cnt = 0;
  int            last_wr_cyc = 0, first_rd_cyc = 0, done_cyc = 0;
  bit            gap_pending = 0;
  logic          done_q = 1'b0;

  wr_t           mon_w;
  logic [AW-1:0] mon_a;
  res_t          mon_r;
  logic [AW-1:0] mdl_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic word_t pat(input int a, input bit inv);
    logic [DW-1:0] lo;
    lo = DW'(a);
    if (inv) lo = ~lo;
    return {~lo, lo};
  endfunction

  always @(posedge clk0) cyc++;

  // Controller model: memory written by write strobes, each read answered lat cycles later, in order.
  always @(negedge clk0) begin
    if (!reset_n) begin
      mdl_q.delete();
      mdl_due.delete();
      usr_rd_dvld = 1'b0;
      usr_rd_data = '0;
    end else begin
      if (usr_wr_strb) mem[usr_addr[TAB-1:0]] = usr_wr_data;
      if (usr_rd_strb) begin
        outst++;
        if (outst > max_outst) max_outst = outst;
        if (!no_ret) begin
          mdl_q.push_back(usr_addr);
          mdl_due.push_back(cyc + lat);
        end
      end
      if (mdl_q.size() > 0 && mdl_due[0] <= cyc) begin
        mdl_a = mdl_q.pop_front();
        void'(mdl_due.pop_front());
        outst--;
        usr_rd_dvld = 1'b1;
        usr_rd_data = mem[mdl_a[TAB-1:0]] ^ flip[mdl_a[TAB-1:0]];
      end else begin
        usr_rd_dvld = 1'b0;
        usr_rd_data = word_t'({$urandom(), $urandom()});
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or completes a run.
  always @(negedge clk0) begin
    if (reset_n) begin
      if (usr_wr_strb || usr_rd_strb)
        chk("strobe_exclusive", 64'(usr_wr_strb & usr_rd_strb), 64'd0);
      if (usr_wr_strb) begin
        strobe_cnt++;
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h, expected none", usr_addr);
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 64'(usr_addr), 64'(mon_w.addr));
          chk("wr_data", 64'(usr_wr_data), 64'(mon_w.data));
          chk("wr_be", 64'(usr_wr_be), 64'hF);
        end
        last_wr_cyc = cyc;
        if (usr_addr == AW'(NW - 1)) gap_pending = 1;
      end
      if (usr_rd_strb) begin
        strobe_cnt++;
        if (gap_pending) begin
          gap_pending = 0;
          first_rd_cyc = cyc;
          chk("wr_rd_gap", 64'(cyc - last_wr_cyc - 1), 64'(GAP));
        end
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0h, expected none", usr_addr);
        end else begin
          mon_a = exp_rd.pop_front();
          chk("rd_addr", 64'(usr_addr), 64'(mon_a));
        end
      end
      if (done && !done_q) begin
        done_cyc = cyc;
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: pass %0b, expected no completion", pass);
        end else begin
          mon_r = exp_res.pop_front();
          chk("res_pass", 64'(pass), 64'(mon_r.pass));
          chk("res_timeout", 64'(timeout), 64'(mon_r.tmo));
          chk("res_err_count", 64'(err_count), 64'(mon_r.errs));
          chk("res_first_err_addr", 64'(first_err_addr), 64'(mon_r.first));
          chk("res_busy_low", 64'(busy), 64'd0);
        end
      end
    end
    done_q = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctl"}, 64'({usr_rd_strb, usr_wr_strb, busy, done, pass, timeout, err_count}), 64'd0);
    chk({tag, "_addr"}, 64'(usr_addr), 64'd0);
    chk({tag, "_data"}, 64'(usr_wr_data), 64'd0);
    chk({tag, "_first"}, 64'(first_err_addr), 64'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (mdl_q.size() != 0 && n < 500) begin tick(1); n++; end
    tick(2);
  endtask

  task automatic setup(input bit inv, input int l, input bit nr);
    drain();
    lat = l; no_ret = nr; outst = 0; max_outst = 0;
    for (int a = 0; a < NW; a++) begin
      exp_wr.push_back('{addr: AW'(a), data: pat(a, inv)});
      exp_rd.push_back(AW'(a));
    end
  endtask

  task automatic push_res(input bit p, input bit t, input int e, input int f);
    exp_res.push_back('{pass: p, tmo: t, errs: 16'(e), first: AW'(f)});
  endtask

  task automatic start_run(input bit inv);
    start = 1'b1; invert = inv;
    tick(1);
    start = 1'b0; invert = 1'($urandom);
    chk("wr_strb_after_start", 64'(usr_wr_strb), 64'd1);
    chk("busy_after_start", 64'({busy, done}), 64'b10);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 1000) begin tick(1); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait: done %0b after %0d cycles, expected 1", done, n);
    end
    tick(2);
  endtask

  task automatic wait_rd();
    int n = 0;
    while (!usr_rd_strb && n < 200) begin tick(1); n++; end
    if (!usr_rd_strb) begin
      checks++; errors++;
      $display("FAIL rd_wait: no read strobe after %0d cycles, expected one", n);
    end
  endtask

  task automatic run_full(input bit inv, input int l);
    setup(inv, l, 0);
    push_res(1, 0, 0, 0);
    start_run(inv);
    wait_done();
    chk("all_ops_issued", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s, e, f, d;
    bit inv;
    reset_n = 1'b0; phy_rdy = 1'b0; start = 1'b0; invert = 1'b0;
    for (int a = 0; a < NW; a++) flip[a] = '0;
    tick(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1; phy_rdy = 1'b1;
    tick(2);

    // Basic run, L=10
    run_full(0, 10);

    // Single-bit corruption at address 5
    flip[5] = word_t'(1);
    setup(0, 10, 0);
    push_res(0, 0, 1, 5);
    start_run(0);
    wait_done();
    flip[5] = '0;

    // No read returns: timeout
    setup(0, 10, 1);
    push_res(0, 1, 0, 0);
    start_run(0);
    wait_done();
    d = done_cyc - first_rd_cyc;
    chk("timeout_window", 64'(d >= RTO && d <= RTO + MO + 1), 64'd1);
    chk("timeout_reads_issued", 64'(exp_rd.size()), 64'd0);
    no_ret = 0;

    // Long latency with inverted pattern: issue caps at MO outstanding
    run_full(1, 30);
    chk("max_outstanding", 64'(max_outst), 64'(MO));

    // Reset mid-READ, then restart
    setup(0, 10, 0);
    start_run(0);
    wait_rd();
    tick(3);
    reset_n = 1'b0;
    tick(1);
    chk_reset_outputs("midrun_reset");
    exp_wr.delete(); exp_rd.delete(); exp_res.delete(); gap_pending = 0;
    reset_n = 1'b1;
    tick(2);
    run_full(0, 10);

    // Start without phy_rdy is ignored
    phy_rdy = 1'b0;
    s = strobe_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk("norun_busy", 64'(busy), 64'd0);
    chk("norun_strobes", 64'(strobe_cnt), 64'(s));
    chk("norun_done_held", 64'(done), 64'd1);
    phy_rdy = 1'b1;
    tick(1);

    // phy_rdy drop during READ aborts
    setup(0, 10, 0);
    push_res(0, 0, 0, 0);
    start_run(0);
    wait_rd();
    tick(4);
    phy_rdy = 1'b0;
    tick(1);
    chk("abort_done_immediate", 64'({done, busy, pass}), 64'b100);
    tick(2);
    exp_wr.delete(); exp_rd.delete();
    phy_rdy = 1'b1;

    // Randomized runs: random polarity, latency and corrupted addresses; stray start mid-run
    for (int r = 0; r < 5; r++) begin
      inv = 1'($urandom);
      e = 0; f = 0;
      for (int a = 0; a < NW; a++) begin
        flip[a] = ($urandom_range(0, 3) == 0) ? word_t'(1) << $urandom_range(0, 2*DW-1) : '0;
        if (flip[a] != '0) begin
          if (e == 0) f = a;
          e++;
        end
      end
      setup(inv, $urandom_range(1, 40), 0);
      push_res(e == 0, 0, e, f);
      start_run(inv);
      tick($urandom_range(1, 20));
      start = 1'b1; invert = ~inv;
      tick(1);
      start = 1'b0;
      wait_done();
      chk("rand_all_ops_issued", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
      for (int a = 0; a < NW; a++) flip[a] = '0;
    end

    drain();
    chk("results_consumed", 64'(exp_res.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
